// File: rtl/tb_rsc_encoder.sv
// Streaming 4-lane LTE RSC encoder (g0=13, g1=15 octal) producing BPSK int8xSIMD systematic/parity beats.
// Define TB_ENC_TAIL_EN to emit the 3-step trellis termination beat carrying sym_last_o.
module tb_rsc_encoder #(
    parameter int Q     = 8,
    parameter int SIMD  = 4,
    parameter int AMP   = 32,
    parameter int LEN_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [LEN_W-1:0]    len_i,
    input  logic                data_valid_i,
    output logic                data_ready_o,
    input  logic [31:0]         data_i,
    output logic                sym_valid_o,
    input  logic                sym_ready_i,
    output logic [Q*SIMD-1:0]   sym_sys_o,
    output logic [Q*SIMD-1:0]   sym_par_o,
    output logic                sym_last_o,
    output logic                busy_o
);

    localparam int SW    = Q * SIMD;
    localparam int BPW   = 32 / SIMD;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [Q-1:0] SYM_BIT0 = Q'(AMP);
    localparam logic [Q-1:0] SYM_BIT1 = Q'(-AMP);

`ifdef TB_ENC_TAIL_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ENC, S_TAIL, S_DRAIN} state_t;
    localparam state_t S_AFTER_DATA = S_TAIL;
    localparam state_t S_EMPTY_BLK  = S_TAIL;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ENC, S_DRAIN} state_t;
    localparam state_t S_AFTER_DATA = S_DRAIN;
    localparam state_t S_EMPTY_BLK  = S_IDLE;
`endif

    state_t             r_state;
    state_t             w_state_next;
    logic [2:0]         r_trellis;
    logic [31:0]        r_word;
    logic [IDX_W-1:0]   r_beat_idx;
    logic [LEN_W-1:0]   r_beats_left;
    logic               r_sym_valid;
    logic [SW-1:0]      r_sym_sys;
    logic [SW-1:0]      r_sym_par;
    logic               r_sym_last;

    logic               w_out_free;
    logic               w_in_load;
    logic               w_start;
    logic               w_accept;
    logic               w_emit_data;
    logic               w_last_data;
    logic [LEN_W-1:0]   w_len_beats;
    logic [IDX_W-1:0]   w_cur_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic [SIMD-1:0]    w_nib;

    assign w_out_free  = !r_sym_valid || sym_ready_i;
    assign w_in_load   = (r_state == S_LOAD);
    assign w_start     = (r_state == S_IDLE) && start_i;
    assign w_accept    = w_in_load && data_valid_i;
    assign w_len_beats = len_i >> 2;
    assign w_last_data = (r_beats_left == LEN_W'(1));
    // In LOAD the first beat of the new word comes straight from data_i.
    assign w_cur_idx   = w_in_load ? '0 : r_beat_idx;
    assign w_idx_next  = w_cur_idx + 1'b1;
    assign w_nib       = w_in_load ? data_i[SIMD-1:0] : r_word[SIMD*r_beat_idx +: SIMD];

    // Data beat: SIMD trellis steps unrolled, state = {s1, s2, s3}.
    logic [2:0]      w_st [0:SIMD];
    logic [SIMD-1:0] w_f;
    logic [SIMD-1:0] w_p;
    logic [SW-1:0]   w_beat_sys;
    logic [SW-1:0]   w_beat_par;

    assign w_st[0] = r_trellis;

    generate
        for (genvar gi = 0; gi < SIMD; gi++) begin : g_step
            assign w_f[gi]     = w_nib[gi] ^ w_st[gi][1] ^ w_st[gi][0];
            assign w_p[gi]     = w_f[gi] ^ w_st[gi][2] ^ w_st[gi][0];
            assign w_st[gi+1]  = {w_f[gi], w_st[gi][2], w_st[gi][1]};
            assign w_beat_sys[Q*gi +: Q] = w_nib[gi] ? SYM_BIT1 : SYM_BIT0;
            assign w_beat_par[Q*gi +: Q] = w_p[gi]   ? SYM_BIT1 : SYM_BIT0;
        end
    endgenerate

`ifdef TB_ENC_TAIL_EN
    // Termination: u = s2^s3 forces the feedback bit to 0, flushing the state in 3 steps.
    logic [2:0]    w_tst [0:2];
    logic [2:0]    w_tu;
    logic [2:0]    w_tp;
    logic [SW-1:0] w_tail_sys;
    logic [SW-1:0] w_tail_par;
    logic          w_emit_tail;

    assign w_tst[0] = r_trellis;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tail
            assign w_tu[gi] = w_tst[gi][1] ^ w_tst[gi][0];
            assign w_tp[gi] = w_tst[gi][2] ^ w_tst[gi][0];
            assign w_tail_sys[Q*gi +: Q] = w_tu[gi] ? SYM_BIT1 : SYM_BIT0;
            assign w_tail_par[Q*gi +: Q] = w_tp[gi] ? SYM_BIT1 : SYM_BIT0;
            if (gi < 2) begin : g_adv
                assign w_tst[gi+1] = {1'b0, w_tst[gi][2], w_tst[gi][1]};
            end
        end
    endgenerate

    assign w_tail_sys[SW-1:3*Q] = '0;
    assign w_tail_par[SW-1:3*Q] = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_emit_data  = 1'b0;
`ifdef TB_ENC_TAIL_EN
        w_emit_tail  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_next = (w_len_beats == '0) ? S_EMPTY_BLK : S_LOAD;
                end
            end
            S_LOAD: begin
                if (data_valid_i) begin
                    if (w_out_free) begin
                        w_emit_data  = 1'b1;
                        w_state_next = w_last_data ? S_AFTER_DATA : S_ENC;
                    end else begin
                        w_state_next = S_ENC;
                    end
                end
            end
            S_ENC: begin
                if (w_out_free) begin
                    w_emit_data = 1'b1;
                    if (w_last_data) begin
                        w_state_next = S_AFTER_DATA;
                    end else if (w_idx_next == '0) begin
                        w_state_next = S_LOAD;
                    end
                end
            end
`ifdef TB_ENC_TAIL_EN
            S_TAIL: begin
                if (w_out_free) begin
                    w_emit_tail  = 1'b1;
                    w_state_next = S_DRAIN;
                end
            end
`endif
            // Final beat is held in the output register until it is taken.
            S_DRAIN: begin
                if (sym_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_trellis    <= '0;
            r_word       <= '0;
            r_beat_idx   <= '0;
            r_beats_left <= '0;
            r_sym_valid  <= 1'b0;
            r_sym_sys    <= '0;
            r_sym_par    <= '0;
            r_sym_last   <= 1'b0;
        end else begin
            if (w_start) begin
                r_trellis    <= '0;
                r_beats_left <= w_len_beats;
            end
            if (w_accept) begin
                r_word     <= data_i;
                r_beat_idx <= '0;
            end
            if (w_emit_data) begin
                r_trellis    <= w_st[SIMD];
                r_beats_left <= r_beats_left - 1'b1;
                r_beat_idx   <= w_idx_next;
                r_sym_valid  <= 1'b1;
                r_sym_sys    <= w_beat_sys;
                r_sym_par    <= w_beat_par;
`ifdef TB_ENC_TAIL_EN
                r_sym_last   <= 1'b0;
`else
                r_sym_last   <= w_last_data;
`endif
            end
`ifdef TB_ENC_TAIL_EN
            else if (w_emit_tail) begin
                r_trellis   <= '0;
                r_sym_valid <= 1'b1;
                r_sym_sys   <= w_tail_sys;
                r_sym_par   <= w_tail_par;
                r_sym_last  <= 1'b1;
            end
`endif
            else if (sym_ready_i) begin
                r_sym_valid <= 1'b0;
            end
        end
    end

    assign data_ready_o = w_in_load;
    assign busy_o       = (r_state != S_IDLE);
    assign sym_valid_o  = r_sym_valid;
    assign sym_sys_o    = r_sym_sys;
    assign sym_par_o    = r_sym_par;
    assign sym_last_o   = r_sym_last;

endmodule
